// File: rtl/debug_reg_dump.sv
// -----------------------------------------------------------------------------
// debug_reg_dump
//
// Walks the register file through its debug read port, from address 0 up to
// CELDAS-1. Each word is latched into a shift register and sent to a UART
// transmitter one byte at a time, most significant byte first, using a
// start/done handshake. A host can then capture the whole register file
// after the program halts.
//
// Ports:
//   i_clk       system clock, all state updates on the rising edge
//   i_reset     synchronous, active-high reset (highest priority)
//   i_start     starts a dump when sampled high in IDLE
//   o_RegAddr   address to the register file debug read port
//   i_RegDato   data from the debug read port (combinational from o_RegAddr)
//   o_tx_data   byte to transmit, valid while o_tx_start is high and held after
//   o_tx_start  one-cycle transmit request
//   i_tx_done   one-cycle pulse: current byte finished
//   o_busy      high in every state except IDLE
//   o_done      one-cycle pulse after the last byte has been acknowledged
// -----------------------------------------------------------------------------
module debug_reg_dump #(
  parameter int REGS   = 5,
  parameter int NBITS  = 32,
  parameter int CELDAS = 32,
  parameter int BYTE   = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic [REGS-1:0]  o_RegAddr,
  input  logic [NBITS-1:0] i_RegDato,
  output logic [BYTE-1:0]  o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_done,
  output logic             o_busy,
  output logic             o_done
);

  localparam int NBEATS = NBITS / BYTE;
  localparam int CNTW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(NBEATS - 1);
  localparam logic [REGS-1:0] LAST_ADDR = REGS'(CELDAS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [REGS-1:0]  r_addr,  w_addr_nxt;
  logic [NBITS-1:0] r_shift, w_shift_nxt;
  logic [CNTW-1:0]  r_cnt,   w_cnt_nxt;

  // State and datapath registers; reset overrides everything, mid-dump included
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_addr  <= {REGS{1'b0}};
      r_shift <= {NBITS{1'b0}};
      r_cnt   <= {CNTW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        // i_tx_done is deliberately ignored here
        if (i_start) begin
          w_addr_nxt  = {REGS{1'b0}};
          w_state_nxt = S_LATCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LATCH: begin
        // Address has been stable for a full cycle, so the read data is settled
        w_shift_nxt = i_RegDato;
        w_cnt_nxt   = {CNTW{1'b0}};
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        // The TX takes at least one cycle, so a done pulse here is spurious
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (r_cnt != LAST_BEAT) begin
            w_shift_nxt = r_shift << BYTE;
            w_cnt_nxt   = r_cnt + CNTW'(1);
            w_state_nxt = S_SEND;
          end else if (r_addr != LAST_ADDR) begin
            w_addr_nxt  = r_addr + REGS'(1);
            w_state_nxt = S_LATCH;
          end else begin
            // Address holds at the last register; no wrap
            w_state_nxt = S_DONE;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // All outputs come from registers or a decode of the state register only
  assign o_RegAddr  = r_addr;
  assign o_tx_data  = r_shift[NBITS-1 -: BYTE];
  assign o_tx_start = (r_state == S_SEND);
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = (r_state == S_DONE);

endmodule

// File: doc/debug_reg_dump.md
Name: debug_reg_dump

Overview:
Debug-side reader for the register file's debug read port. On a start command it walks every register, from address 0 to CELDAS-1. Each word is split into bytes and handed, one at a time, to the UART transmitter through a start/done handshake, so a host can capture the whole register file contents after a program halts. It sits between the register file debug port and the UART TX in the debug unit.

Parameters:
REGS, 5, register address width
NBITS, 32, register data width; must be a multiple of BYTE
CELDAS, 32, number of registers dumped; CELDAS <= 2**REGS
BYTE, 8, width of one transmitted byte

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  level or pulse; starts a dump when sampled high in IDLE
o_RegAddr  output  REGS  address driven to register file debug read port
i_RegDato  input  NBITS  data returned by debug read port (combinational from o_RegAddr)
o_tx_data  output  BYTE  byte to transmit
o_tx_start  output  1  one-cycle request to UART TX; o_tx_data valid in that cycle
i_tx_done  input  1  one-cycle pulse from UART TX: current byte finished
o_busy  output  1  high in every state except IDLE
o_done  output  1  one-cycle pulse after the last byte's i_tx_done

Behaviour:
- Synchronous reset is active-high and takes priority over all other inputs, in any state, mid-dump included:
  - state goes to IDLE.
  - o_RegAddr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0.
  - internal shift register and byte counter are cleared.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.
- States: IDLE, LATCH, SEND, WAIT, DONE.
- IDLE:
  - i_start=1 -> o_RegAddr<=0, go to LATCH.
  - Otherwise stay. i_tx_done is ignored.
- LATCH: shift_reg<=i_RegDato (address was stable for one full cycle), byte_cnt<=0, go to SEND.
- SEND:
  - o_tx_start=1 for exactly this one cycle.
  - o_tx_data = shift_reg[NBITS-1 -: BYTE]; most significant byte goes first.
  - go to WAIT.
  - i_tx_done in SEND is ignored; the TX is required to take at least one cycle.
- WAIT: hold o_tx_data, o_tx_start=0.
  - On i_tx_done with byte_cnt < NBITS/BYTE-1: shift_reg <<= BYTE, byte_cnt++, go to SEND.
  - On i_tx_done with the last byte and o_RegAddr < CELDAS-1: o_RegAddr++, go to LATCH.
  - On i_tx_done with the last byte and o_RegAddr == CELDAS-1: go to DONE. o_RegAddr holds; no wrap.
- DONE: o_done=1 for one cycle, go to IDLE. o_RegAddr resets to 0 on the next start.
- i_start while o_busy=1 is ignored. No restart and no queuing.
- If i_start is still high when DONE returns to IDLE, a new dump starts on the following cycle. The host is required to pulse i_start.
- Latency:
  - start sampled at edge k -> LATCH at k+1 -> first o_tx_start high in cycle k+2.
  - Between i_tx_done and the next o_tx_start: 1 cycle within a word, 2 cycles across words.
- Total bytes per dump: CELDAS*NBITS/BYTE (128 with defaults).
- Register contents changing during a dump: each word is a snapshot taken in LATCH. Later changes affect only later registers.

Test Plan:
- Reset: i_reset=1 for 2 cycles at any state -> all outputs 0, o_busy=0. Assert reset mid-dump after the 3rd byte -> IDLE next edge; no further o_tx_start.
- Full dump with reg[i]=i, TX model replying with i_tx_done 10 cycles after each start:
  - exactly 128 o_tx_start pulses.
  - bytes 0-3 = 00 00 00 00; bytes 4-7 = 00 00 00 01; last 4 = 00 00 00 1F.
  - single o_done pulse; o_busy falls with it.
- Byte order: reg[5]=32'hDEADBEEF -> bytes 20-23 = DE AD BE EF.
- Handshake timing:
  - i_tx_done 1 cycle after start -> next o_tx_start exactly 1 cycle later within a word, 2 cycles across words.
  - random 1-30 cycle delays -> same byte stream.
- Spurious inputs: i_tx_done pulses in IDLE and in SEND -> no state advance. i_start pulses during a dump -> ignored, stream unchanged, still 128 bytes.
- Back-to-back: i_start pulsed again right after o_done -> second dump restarts from address 0 and produces an identical stream.
